// File: rtl/dtw_pkg.sv
// dtw_pkg: shared defaults and FSM state encoding for the DTW feeder.
package dtw_pkg;
  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_SIZE = 602;
  localparam int DEF_IDX_WIDTH = 10;
  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
endpackage

// File: rtl/dtw_sample_buf.sv
// dtw_sample_buf: sample buffer with write port and registered, saturating read-on-request port.
module dtw_sample_buf #(
  parameter int DATA_WIDTH = 10,
  parameter int SIZE = 602,
  parameter int IDX_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic                  req,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty
);
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(SIZE);
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [IDX_WIDTH-1:0]  idx;
  assign empty = idx == LAST;
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q   <= '0;
      idx <= '0;
    end else if (clr) idx <= '0;
    else if (req && !empty) begin
      q   <= mem[idx];
      idx <= idx + 1'b1;
    end
endmodule

// File: rtl/dtw_feeder.sv
// dtw_feeder: loads refer/camera sequences and streams them to a DTW engine, capturing its score.
module dtw_feeder
  import dtw_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SIZE = DEF_SIZE,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_reject,
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  input  logic                  ready_refer,
  input  logic                  ready_camera,
  output logic [DATA_WIDTH-1:0] refer,
  output logic [DATA_WIDTH-1:0] camera,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] score,
  output logic [DATA_WIDTH-1:0] score_out,
  output logic                  score_valid,
  output logic                  underrun
);
  localparam logic [IDX_WIDTH-1:0] SZ = IDX_WIDTH'(SIZE);
  state_t state, state_n;
  logic   idle, run, wr_ok, clr, req_r, req_c, empty_r, empty_c;
  assign idle = state == IDLE;
  assign run = state == RUN;
  assign busy = !idle;
  assign ready = run;
  assign score_valid = state == REPORT;
  assign wr_ok = wr_en && idle && wr_addr < SZ;
  assign clr = start && idle;
  assign req_r = ready_refer && run;
  assign req_c = ready_camera && run;
  always_comb begin
    state_n = state;
    if (clr) state_n = RUN;
    else if (run && done) state_n = REPORT;
    else if (score_valid) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      wr_reject <= 1'b0;
      underrun  <= 1'b0;
      score_out <= '0;
    end else begin
      state     <= state_n;
      wr_reject <= wr_en && !wr_ok;
      if (clr) underrun <= 1'b0;
      else if ((req_r && empty_r) || (req_c && empty_c)) underrun <= 1'b1;
      if (run && done) score_out <= score;
    end
  dtw_sample_buf #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE), .IDX_WIDTH(IDX_WIDTH)) u_refer (
    .clk(clk), .rst(rst), .we(wr_ok && !wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .req(req_r), .q(refer), .empty(empty_r)
  );
  dtw_sample_buf #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE), .IDX_WIDTH(IDX_WIDTH)) u_camera (
    .clk(clk), .rst(rst), .we(wr_ok && wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .req(req_c), .q(camera), .empty(empty_c)
  );
endmodule

// File: tb/tb_dtw_feeder.sv
// tb_dtw_feeder: directed scenario tests for dtw_feeder with a simple engine model.
module tb_dtw_feeder;
  logic       clk = 1'b0, rst = 1'b0;
  logic       wr_en = 1'b0, wr_sel = 1'b0;
  logic [9:0] wr_addr = '0, wr_data = '0;
  logic       wr_reject, start = 1'b0, busy, ready;
  logic       ready_refer = 1'b0, ready_camera = 1'b0;
  logic [9:0] refer, camera;
  logic       done = 1'b0;
  logic [9:0] score = '0, score_out;
  logic       score_valid, underrun;
  int         tests = 0, fails = 0;

  dtw_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_reject(wr_reject), .start(start), .busy(busy), .ready(ready),
    .ready_refer(ready_refer), .ready_camera(ready_camera), .refer(refer), .camera(camera),
    .done(done), .score(score), .score_out(score_out), .score_valid(score_valid),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  task automatic load();
    wr_en = 1'b1;
    for (int i = 0; i < 602; i++) begin
      wr_sel = 1'b0; wr_addr = 10'(i); wr_data = 10'(i);
      step();
      wr_sel = 1'b1; wr_data = 10'(602 - i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if ({busy, ready, score_valid, wr_reject, underrun} !== 5'b0 || refer !== 10'd0 ||
        camera !== 10'd0 || score_out !== 10'd0) begin
      fails++;
      $display("FAIL reset: busy=%b ready=%b sv=%b rej=%b ur=%b refer=%0d camera=%0d score_out=%0d, required all 0",
               busy, ready, score_valid, wr_reject, underrun, refer, camera, score_out);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    pulse_start();
    tests++;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_ready: ready=%b busy=%b, required 1 1", ready, busy);
    end
    ready_refer = 1'b1; ready_camera = 1'b1;
    for (int i = 0; i < 602; i++) begin
      step();
      tests++;
      if (refer !== 10'(i) || camera !== 10'(602 - i)) begin
        fails++;
        $display("FAIL stream[%0d]: refer=%0d camera=%0d, required %0d %0d", i, refer, camera, i, 602 - i);
      end
    end
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL stream_underrun: underrun=%b, required 0", underrun);
    end
  endtask

  task automatic test_underrun();
    ready_camera = 1'b0;
    step();
    ready_refer = 1'b0;
    tests++;
    if (refer !== 10'd601 || underrun !== 1'b1 || camera !== 10'd1) begin
      fails++;
      $display("FAIL underrun: refer=%0d camera=%0d underrun=%b, required 601 1 1", refer, camera, underrun);
    end
    step();
    tests++;
    if (underrun !== 1'b1) begin
      fails++;
      $display("FAIL underrun_sticky: underrun=%b, required 1", underrun);
    end
  endtask

  task automatic test_score();
    done = 1'b1; score = 10'd37;
    step();
    done = 1'b0; score = 10'd0;
    tests++;
    if (score_out !== 10'd37 || score_valid !== 1'b1 || ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL score_report: score_out=%0d sv=%b ready=%b busy=%b, required 37 1 0 1",
               score_out, score_valid, ready, busy);
    end
    step();
    tests++;
    if (score_valid !== 1'b0 || busy !== 1'b0 || score_out !== 10'd37) begin
      fails++;
      $display("FAIL score_after: sv=%b busy=%b score_out=%0d, required 0 0 37", score_valid, busy, score_out);
    end
    done = 1'b1; score = 10'd5;
    step();
    done = 1'b0;
    tests++;
    if (score_valid !== 1'b0 || score_out !== 10'd37 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_idle: sv=%b score_out=%0d busy=%b, required 0 37 0", score_valid, score_out, busy);
    end
    ready_refer = 1'b1;
    step();
    ready_refer = 1'b0;
    tests++;
    if (refer !== 10'd601 || underrun !== 1'b1) begin
      fails++;
      $display("FAIL req_idle: refer=%0d underrun=%b, required 601 1", refer, underrun);
    end
  endtask

  task automatic test_wr_reject();
    pulse_start();
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL underrun_clear: underrun=%b, required 0", underrun);
    end
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 10'd5; wr_data = 10'd999;
    step();
    wr_en = 1'b0;
    tests++;
    if (wr_reject !== 1'b1) begin
      fails++;
      $display("FAIL rej_busy: wr_reject=%b, required 1", wr_reject);
    end
    step();
    tests++;
    if (wr_reject !== 1'b0) begin
      fails++;
      $display("FAIL rej_pulse: wr_reject=%b, required 0", wr_reject);
    end
    finish_run();
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 10'd602; wr_data = 10'd777;
    step();
    wr_en = 1'b0;
    tests++;
    if (wr_reject !== 1'b1) begin
      fails++;
      $display("FAIL rej_addr: wr_reject=%b, required 1", wr_reject);
    end
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 10'd3; wr_data = 10'd599;
    step();
    wr_en = 1'b0;
    tests++;
    if (wr_reject !== 1'b0) begin
      fails++;
      $display("FAIL rej_ok: wr_reject=%b, required 0", wr_reject);
    end
    pulse_start();
    ready_refer = 1'b1; ready_camera = 1'b1;
    for (int i = 0; i < 602; i++) begin
      step();
      if (i == 5 || i == 3 || i == 601) begin
        tests++;
        if (refer !== 10'(i) || camera !== 10'(602 - i)) begin
          fails++;
          $display("FAIL readback[%0d]: refer=%0d camera=%0d, required %0d %0d", i, refer, camera, i, 602 - i);
        end
      end
    end
    ready_refer = 1'b0; ready_camera = 1'b0;
    finish_run();
  endtask

  task automatic test_rst_mid_run();
    int sv_seen = 0;
    pulse_start();
    ready_refer = 1'b1;
    repeat (300) step();
    ready_refer = 1'b0;
    tests++;
    if (refer !== 10'd299) begin
      fails++;
      $display("FAIL pre_rst: refer=%0d, required 299", refer);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, ready, score_valid, wr_reject, underrun} !== 5'b0 || refer !== 10'd0 ||
        camera !== 10'd0 || score_out !== 10'd0) begin
      fails++;
      $display("FAIL rst_mid: busy=%b ready=%b sv=%b rej=%b ur=%b refer=%0d camera=%0d score_out=%0d, required all 0",
               busy, ready, score_valid, wr_reject, underrun, refer, camera, score_out);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (score_valid !== 1'b0 || busy !== 1'b0) sv_seen++;
    end
    tests++;
    if (sv_seen != 0) begin
      fails++;
      $display("FAIL rst_no_report: %0d cycles with sv/busy set, required 0", sv_seen);
    end
    pulse_start();
    ready_refer = 1'b1; ready_camera = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (refer !== 10'(i) || camera !== 10'(602 - i)) begin
        fails++;
        $display("FAIL replay[%0d]: refer=%0d camera=%0d, required %0d %0d", i, refer, camera, i, 602 - i);
      end
    end
    ready_refer = 1'b0; ready_camera = 1'b0;
  endtask

  task automatic test_back_to_back();
    done = 1'b1; score = 10'd123; ready_refer = 1'b1; start = 1'b1;
    step();
    done = 1'b0; score = 10'd0; ready_refer = 1'b0; start = 1'b0;
    tests++;
    if (refer !== 10'd4 || camera !== 10'd599 || score_out !== 10'd123 || score_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_edge: refer=%0d camera=%0d score_out=%0d sv=%b, required 4 599 123 1",
               refer, camera, score_out, score_valid);
    end
    step();
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || score_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: busy=%b ready=%b sv=%b, required 0 0 0", busy, ready, score_valid);
    end
    step();
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_start_ignored: busy=%b ready=%b, required 0 0", busy, ready);
    end
  endtask

  initial begin
    test_reset();
    load();
    test_stream();
    test_underrun();
    test_score();
    test_wr_reject();
    test_rst_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dtw_feeder.md
DTW_FEEDER -- requirements
Module: dtw_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 10: sample and score width.
REQ-002 Parameter SIZE, default 602: samples per sequence, per channel.
REQ-003 Parameter IDX_WIDTH, default 10: counter/address width; SHALL satisfy 2**IDX_WIDTH > SIZE.
REQ-004 clk  input  1  single clock, all logic posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  load-port write strobe.
REQ-007 wr_sel  input  1  load target: 0 = refer buffer, 1 = camera buffer.
REQ-008 wr_addr  input  IDX_WIDTH  load address, 0..SIZE-1.
REQ-009 wr_data  input  DATA_WIDTH  load data.
REQ-010 wr_reject  output  1  one-cycle pulse: write dropped (busy or address >= SIZE).
REQ-011 start  input  1  one-cycle run request.
REQ-012 busy  output  1  high outside IDLE.
REQ-013 ready  output  1  run-enable to the DTW engine.
REQ-014 ready_refer  input  1  engine requests the next refer sample.
REQ-015 ready_camera  input  1  engine requests the next camera sample.
REQ-016 refer  output  DATA_WIDTH  refer sample to the engine.
REQ-017 camera  output  DATA_WIDTH  camera sample to the engine.
REQ-018 done  input  1  engine result valid.
REQ-019 score  input  DATA_WIDTH  engine score.
REQ-020 score_out  output  DATA_WIDTH  captured score.
REQ-021 score_valid  output  1  one-cycle pulse when score_out updates.
REQ-022 underrun  output  1  sticky: a request arrived after a channel was exhausted.

Function
REQ-023 Two SIZE x DATA_WIDTH buffers; a write in IDLE with wr_addr < SIZE SHALL update buffer[wr_sel][wr_addr] at the clock edge.
REQ-024 A write while busy, or with wr_addr >= SIZE, SHALL not modify either buffer and SHALL pulse wr_reject the next cycle.
REQ-025 FSM states IDLE, RUN, REPORT; reset state IDLE.
REQ-026 IDLE -> RUN on start: clear ref_idx, cam_idx and underrun; set ready = 1 from the next cycle.
REQ-027 In RUN, at an edge with ready_refer = 1 and ref_idx < SIZE: refer <= refer_buf[ref_idx] and ref_idx increments, so the sample is valid the cycle after the request; camera channel identical and independent.
REQ-028 refer and camera SHALL hold their last value when not requested.
REQ-029 A request with its index == SIZE SHALL leave the output and index unchanged and set underrun.
REQ-030 RUN -> REPORT at an edge with done = 1: score_out <= score and ready <= 0; a sample request at the same edge SHALL still be served.
REQ-031 REPORT SHALL assert score_valid for exactly one cycle, then go to IDLE.
REQ-032 start outside IDLE, and done outside RUN, SHALL be ignored.
REQ-033 ready_refer and ready_camera outside RUN SHALL be ignored; no index change, no underrun.
REQ-034 Indices SHALL saturate at SIZE and never wrap.

Reset
REQ-035 On rst, asynchronously: state IDLE; ready, busy, score_valid, wr_reject and underrun 0; refer, camera and score_out 0; ref_idx and cam_idx 0.
REQ-036 Buffer contents SHALL not be reset.
REQ-037 rst asserted mid-RUN SHALL abort the run with no score_valid pulse.

Structure
REQ-038 A shared package dtw_pkg SHALL hold DATA_WIDTH, SIZE and IDX_WIDTH defaults and the FSM state enum.
REQ-039 One sub-module, dtw_sample_buf, SHALL be instantiated once per channel: write port plus a registered read-on-request port with saturating index.

Verification
REQ-040 Load refer[i] = i and camera[i] = 602-i, start, engine model requests every cycle -> 1st refer = 0 and camera = 602 one cycle after the first request; refer = 601 and camera = 1 at index 601; underrun = 0.
REQ-041 Engine model issues 603 ready_refer requests -> the 603rd leaves refer = 601 and sets underrun = 1; start clears it.
REQ-042 done = 1 with score = 10'd37 in RUN -> score_out = 37, score_valid high for exactly one cycle, busy low the cycle after, ready low from the done edge.
REQ-043 wr_en during RUN, and wr_addr = 602 in IDLE -> wr_reject pulses each time and the buffer readback is unchanged.
REQ-044 rst pulse at ref_idx = 300 -> all outputs 0 immediately, no score_valid; a new start replays from index 0 with the buffers intact.
REQ-045 done and ready_refer at the same edge, with start asserted while busy -> the sample is delivered, the score is captured, and start is ignored.
